// File: rtl/audio_mixer_multich_if.sv
// ZX-Uno register-port bundle between the CPU bus decoder (master) and the mixer (slave).
interface audio_mixer_multich_if;
  logic [7:0] zxuno_addr;
  logic       zxuno_regrd;
  logic       zxuno_regwr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       oe_n;

  modport master (
    output zxuno_addr, zxuno_regrd, zxuno_regwr, din,
    input  dout, oe_n
  );

  modport slave (
    input  zxuno_addr, zxuno_regrd, zxuno_regwr, din,
    output dout, oe_n
  );
endinterface

// File: rtl/audio_mixer_multich.sv
// N-channel audio mixer: per-channel volume registers on the ZX-Uno port,
// a time-multiplexed MAC sequencer producing a saturated PCM sample, and a
// first-order sigma-delta DAC running every clock.
// Optional build macro: MIXER_STEREO_EN adds per-channel L/R routing, a second
// accumulator/saturator and a second modulator (pcm_out reports the left path).
//
// state | meaning
// IDLE  | waiting for sample_tick
// LOAD  | snapshot ch_in, clear accumulators
// ACC   | one channel per clk: acc += ch[k]*vol[k]
// DONE  | sample published (pcm_valid high), back to IDLE
module audio_mixer_multich #(
  parameter int         NUM_CH  = 8,
  parameter int         CH_W    = 8,
  parameter int         VOL_W   = 4,
  parameter logic [7:0] REG_IDX = 8'hF6,
  parameter logic [7:0] REG_VOL = 8'hF7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_tick,
  input  logic [NUM_CH*CH_W-1:0]   ch_in,
  audio_mixer_multich_if.slave     zx,
  output logic [CH_W-1:0]          pcm_out,
  output logic                     pcm_valid,
  output logic                     audio_out_l,
  output logic                     audio_out_r
);

  localparam int KW     = $clog2(NUM_CH);
  localparam int PROD_W = CH_W + VOL_W;
  // Sized so NUM_CH full-scale products can never wrap.
  localparam int ACC_W  = CH_W + VOL_W + KW;
  localparam int PCM_MAX = (2 ** CH_W) - 1;
  localparam logic [VOL_W-1:0] VOL_RST = VOL_W'(2 ** (VOL_W - 1));

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ACC, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [KW-1:0]     cnt_q, cnt_d;
  logic [3:0]        idx_q, idx_d;
  logic [VOL_W-1:0]  vol_q [NUM_CH];
  logic [VOL_W-1:0]  vol_d [NUM_CH];
  logic [CH_W-1:0]   ch_q  [NUM_CH];
  logic [CH_W-1:0]   ch_d  [NUM_CH];
  logic [ACC_W-1:0]  acc_l_q, acc_l_d, acc_l_next;
  logic [CH_W-1:0]   pcm_l_q, pcm_l_d;
  logic              pcm_valid_q, pcm_valid_d;
  logic [CH_W:0]     sd_l_q, sd_l_d;

  logic [CH_W-1:0]   cur_ch;
  logic [VOL_W-1:0]  cur_vol;
  logic [PROD_W-1:0] prod;
  logic [VOL_W-1:0]  sel_vol;
  logic [1:0]        sel_route;
  logic [7:0]        vol_byte;
  logic              hit_idx, hit_vol, rd_en;
  logic              unused_din;

`ifdef MIXER_STEREO_EN
  logic [1:0]        route_q [NUM_CH];
  logic [1:0]        route_d [NUM_CH];
  logic [1:0]        cur_route;
  logic [ACC_W-1:0]  acc_r_q, acc_r_d, acc_r_next;
  logic [CH_W-1:0]   pcm_r_q, pcm_r_d;
  logic [CH_W:0]     sd_r_q, sd_r_d;
`endif

  // Only the low data bits carry register content.
  assign unused_din = ^zx.din;

  function automatic logic [CH_W-1:0] saturate(input logic [ACC_W-1:0] a);
    logic [ACC_W-1:0] s;
    s = a >> VOL_W;
    if (s > ACC_W'(PCM_MAX)) return '1;
    return s[CH_W-1:0];
  endfunction

  // Register file: idx/vol/route writes and combinational read-back.
  always_comb begin
    idx_d     = idx_q;
    vol_d     = vol_q;
    sel_vol   = '0;
    sel_route = 2'b00;
`ifdef MIXER_STEREO_EN
    route_d   = route_q;
`endif
    hit_idx = (zx.zxuno_addr == REG_IDX);
    hit_vol = (zx.zxuno_addr == REG_VOL);
    if (zx.zxuno_regwr && hit_idx) idx_d = zx.din[3:0];
    // idx values beyond the last channel match no slot, so such writes drop.
    for (int k = 0; k < NUM_CH; k++) begin
      if (idx_q == 4'(k)) begin
        sel_vol = vol_q[k];
`ifdef MIXER_STEREO_EN
        sel_route = route_q[k];
`endif
        if (zx.zxuno_regwr && hit_vol) begin
          vol_d[k] = zx.din[VOL_W-1:0];
`ifdef MIXER_STEREO_EN
          route_d[k] = zx.din[5:4];
`endif
        end
      end
    end
    vol_byte = 8'(sel_vol) | {2'b00, sel_route, 4'h0};
    rd_en    = zx.zxuno_regrd & (hit_idx | hit_vol);
    zx.oe_n  = ~rd_en;
    zx.dout  = 8'h00;
    if (rd_en) zx.dout = hit_idx ? {4'h0, idx_q} : vol_byte;
  end

  // Mix sequencer: next state, MAC step and saturation on the last channel.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ch_d        = ch_q;
    acc_l_d     = acc_l_q;
    pcm_l_d     = pcm_l_q;
    pcm_valid_d = 1'b0;
    cur_ch      = '0;
    cur_vol     = '0;
`ifdef MIXER_STEREO_EN
    cur_route   = 2'b00;
    acc_r_d     = acc_r_q;
    pcm_r_d     = pcm_r_q;
`endif
    for (int k = 0; k < NUM_CH; k++) begin
      if (cnt_q == KW'(k)) begin
        cur_ch  = ch_q[k];
        cur_vol = vol_q[k];
`ifdef MIXER_STEREO_EN
        cur_route = route_q[k];
`endif
      end
    end
    prod = PROD_W'(cur_ch) * PROD_W'(cur_vol);
`ifdef MIXER_STEREO_EN
    acc_l_next = acc_l_q + (cur_route[0] ? ACC_W'(prod) : '0);
    acc_r_next = acc_r_q + (cur_route[1] ? ACC_W'(prod) : '0);
`else
    acc_l_next = acc_l_q + ACC_W'(prod);
`endif
    case (state_q)
      S_IDLE: if (sample_tick) state_d = S_LOAD;
      S_LOAD: begin
        for (int k = 0; k < NUM_CH; k++) ch_d[k] = ch_in[k*CH_W +: CH_W];
        acc_l_d = '0;
`ifdef MIXER_STEREO_EN
        acc_r_d = '0;
`endif
        cnt_d   = '0;
        state_d = S_ACC;
      end
      S_ACC: begin
        acc_l_d = acc_l_next;
`ifdef MIXER_STEREO_EN
        acc_r_d = acc_r_next;
`endif
        if (cnt_q == KW'(NUM_CH - 1)) begin
          // Saturate from the final sum so the sample is visible in DONE.
          pcm_l_d     = saturate(acc_l_next);
`ifdef MIXER_STEREO_EN
          pcm_r_d     = saturate(acc_r_next);
`endif
          pcm_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sigma-delta modulators: carry out of the CH_W-bit residue is the bitstream.
  always_comb begin
    sd_l_d = {1'b0, sd_l_q[CH_W-1:0]} + {1'b0, pcm_l_q};
`ifdef MIXER_STEREO_EN
    sd_r_d = {1'b0, sd_r_q[CH_W-1:0]} + {1'b0, pcm_r_q};
`endif
  end

  // State registers; reset aborts any cycle in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      acc_l_q     <= '0;
      pcm_l_q     <= '0;
      pcm_valid_q <= 1'b0;
      sd_l_q      <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        vol_q[k] <= VOL_RST;
        ch_q[k]  <= '0;
      end
`ifdef MIXER_STEREO_EN
      for (int k = 0; k < NUM_CH; k++) route_q[k] <= 2'b11;
      acc_r_q <= '0;
      pcm_r_q <= '0;
      sd_r_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      acc_l_q     <= acc_l_d;
      pcm_l_q     <= pcm_l_d;
      pcm_valid_q <= pcm_valid_d;
      sd_l_q      <= sd_l_d;
      vol_q       <= vol_d;
      ch_q        <= ch_d;
`ifdef MIXER_STEREO_EN
      route_q <= route_d;
      acc_r_q <= acc_r_d;
      pcm_r_q <= pcm_r_d;
      sd_r_q  <= sd_r_d;
`endif
    end
  end

  assign pcm_out     = pcm_l_q;
  assign pcm_valid   = pcm_valid_q;
  assign audio_out_l = sd_l_q[CH_W];
`ifdef MIXER_STEREO_EN
  assign audio_out_r = sd_r_q[CH_W];
`else
  assign audio_out_r = sd_l_q[CH_W];
`endif

endmodule

// File: tb/tb_audio_mixer_multich.sv
// Directed bench for audio_mixer_multich (8 channels, 8-bit samples, 4-bit volume).
module tb_audio_mixer_multich;
  localparam logic [7:0] A_IDX = 8'hF6;
  localparam logic [7:0] A_VOL = 8'hF7;
`ifdef MIXER_STEREO_EN
  localparam logic [7:0] DEF_RD = 8'h38;
`else
  localparam logic [7:0] DEF_RD = 8'h08;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_tick;
  logic [63:0] ch_in;
  logic [7:0]  pcm_out;
  logic        pcm_valid, audio_out_l, audio_out_r;

  audio_mixer_multich_if bus ();

  audio_mixer_multich dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .ch_in(ch_in), .zx(bus),
    .pcm_out(pcm_out), .pcm_valid(pcm_valid),
    .audio_out_l(audio_out_l), .audio_out_r(audio_out_r)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [63:0] ch;
    logic [31:0] vols;
    logic [7:0]  exp_pcm;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_near(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act < exp - tol || act > exp + tol) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d+-%0d", name, act, exp, tol);
    end
  endtask

  task automatic reg_write(input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk);
    bus.zxuno_addr  = addr;
    bus.din         = data;
    bus.zxuno_regwr = 1'b1;
    @(negedge clk);
    bus.zxuno_regwr = 1'b0;
  endtask

  task automatic reg_read(input logic [7:0] addr, output logic [7:0] d, output logic oe);
    @(negedge clk);
    bus.zxuno_addr  = addr;
    bus.zxuno_regrd = 1'b1;
    #1;
    d  = bus.dout;
    oe = bus.oe_n;
    bus.zxuno_regrd = 1'b0;
  endtask

  // Programs vol[k] for all channels with route 11 (route bits ignored in mono).
  task automatic set_vols(input logic [31:0] vols);
    for (int k = 0; k < 8; k++) begin
      reg_write(A_IDX, 8'(k));
      reg_write(A_VOL, 8'h30 | 8'(vols[k*4 +: 4]));
    end
  endtask

  // Fires one sample_tick; lat is the negedge count at which pcm_valid is first
  // seen (NUM_CH+2 = 10 expected). dup_at>0 re-asserts the tick mid-cycle.
  task automatic run_mix(input int dup_at, output logic [7:0] pcm, output int lat, output int pulses);
    lat = -1; pulses = 0; pcm = 8'hxx;
    @(negedge clk);
    sample_tick = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 1) sample_tick = 1'b0;
      if (i == dup_at) sample_tick = 1'b1;
      if (i == dup_at + 1) sample_tick = 1'b0;
      if (pcm_valid) begin
        pulses++;
        if (lat < 0) begin lat = i; pcm = pcm_out; end
      end
    end
  endtask

  task automatic duty(input int n, output int ones_l, output int ones_r);
    ones_l = 0; ones_r = 0;
    repeat (n) begin
      @(negedge clk);
      ones_l += int'(audio_out_l);
      ones_r += int'(audio_out_r);
    end
  endtask

  logic [7:0] rd, pcm;
  logic       oe;
  int         lat, pulses, ol, orr;

  initial begin
    vecs[0] = '{"ch0_ff_def",   64'h00000000000000FF, 32'h88888888, 8'h7F};
    vecs[1] = '{"all_ff_v15",   64'hFFFFFFFFFFFFFFFF, 32'hFFFFFFFF, 8'hFF};
    vecs[2] = '{"all_10_v8",    64'h1010101010101010, 32'h88888888, 8'h40};
    vecs[3] = '{"ch0_ch7_mix",  64'h8000000000000080, 32'h20000001, 8'h18};
    vecs[4] = '{"vol_zero",     64'h2020202020202020, 32'h00000000, 8'h00};
    vecs[5] = '{"near_sat",     64'h00000011FF000000, 32'h0001F000, 8'hF0};
    vecs[6] = '{"exact_4080",   64'h000000000000FFFF, 32'h0000001F, 8'hFF};

    rst = 1'b1; sample_tick = 1'b0; ch_in = '0;
    bus.zxuno_addr = 8'h00; bus.zxuno_regrd = 1'b0; bus.zxuno_regwr = 1'b0; bus.din = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_pcm_out", pcm_out, 8'h00);
    check("rst_pcm_valid", pcm_valid, 1'b0);
    check("rst_audio_l", audio_out_l, 1'b0);
    check("rst_audio_r", audio_out_r, 1'b0);
    check("rst_oe_n", bus.oe_n, 1'b1);
    check("rst_dout", bus.dout, 8'h00);
    reg_read(A_IDX, rd, oe);
    check("rst_idx", rd, 8'h00);
    for (int k = 0; k < 8; k++) begin
      reg_write(A_IDX, 8'(k));
      reg_read(A_VOL, rd, oe);
      check($sformatf("rst_vol%0d", k), rd, DEF_RD);
      check("rd_oe_n", oe, 1'b0);
    end
    @(negedge clk);
    check("idle_oe_n", bus.oe_n, 1'b1);

    // Table: program vols, mix, then bitstream density over 10 DAC periods.
    foreach (vecs[v]) begin
      set_vols(vecs[v].vols);
      ch_in = vecs[v].ch;
      run_mix(0, pcm, lat, pulses);
      check({vecs[v].name, "_pcm"}, pcm, vecs[v].exp_pcm);
      check({vecs[v].name, "_latency"}, lat, 10);
      check({vecs[v].name, "_pulses"}, pulses, 1);
      duty(2560, ol, orr);
      check_near({vecs[v].name, "_duty_l"}, ol, 10 * int'(vecs[v].exp_pcm), 1);
      check_near({vecs[v].name, "_duty_r"}, orr, 10 * int'(vecs[v].exp_pcm), 1);
    end

    // Out-of-range index: write dropped, reads return 00 / index.
    set_vols(32'h88888888);
    reg_write(A_IDX, 8'h09);
    reg_write(A_VOL, 8'h0F);
    reg_read(A_VOL, rd, oe);
    check("idx9_vol_rd", rd, 8'h00);
    reg_read(A_IDX, rd, oe);
    check("idx9_idx_rd", rd, 8'h09);
    for (int k = 0; k < 8; k++) begin
      reg_write(A_IDX, 8'(k));
      reg_read(A_VOL, rd, oe);
      check($sformatf("idx9_keep_vol%0d", k), rd, DEF_RD);
    end

    // Second tick three clocks into the cycle must be ignored.
    ch_in = 64'h00000000000000FF;
    run_mix(3, pcm, lat, pulses);
    check("dup_tick_pulses", pulses, 1);
    check("dup_tick_latency", lat, 10);
    check("dup_tick_pcm", pcm, 8'h7F);

    // Reset during ACC clk 4: no pulse, everything back to reset values.
    set_vols(32'h77777777);
    @(negedge clk);
    sample_tick = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) sample_tick = 1'b0;
      if (pcm_valid) pulses++;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pcm_valid) pulses++;
    end
    check("abort_pulses", pulses, 0);
    check("abort_pcm_out", pcm_out, 8'h00);
    check("abort_audio_l", audio_out_l, 1'b0);
    check("abort_audio_r", audio_out_r, 1'b0);
    check("abort_oe_n", bus.oe_n, 1'b1);
    reg_write(A_IDX, 8'h03);
    reg_read(A_VOL, rd, oe);
    check("abort_vol3", rd, DEF_RD);
    run_mix(0, pcm, lat, pulses);
    check("after_abort_pcm", pcm, 8'h7F);
    check("after_abort_latency", lat, 10);

`ifdef MIXER_STEREO_EN
    // ch1 to left only, ch2 to right only.
    for (int k = 0; k < 8; k++) begin
      reg_write(A_IDX, 8'(k));
      reg_write(A_VOL, 8'h00);
    end
    reg_write(A_IDX, 8'h01);
    reg_write(A_VOL, 8'h1F);
    reg_write(A_IDX, 8'h02);
    reg_write(A_VOL, 8'h2F);
    reg_read(A_VOL, rd, oe);
    check("st_route_rd", rd, 8'h2F);
    ch_in = 64'h0000000000408000;
    run_mix(0, pcm, lat, pulses);
    check("st_pcm_l", pcm, 8'h78);
    duty(2560, ol, orr);
    check_near("st_duty_l", ol, 1200, 1);
    check_near("st_duty_r", orr, 600, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
